// File: rtl/alu_unit.sv
// Registered integer ALU for the RV32 execute stage: add/sub, full-width
// unsigned multiply, bitwise logic and logical shifts, one cycle of latency.
module alu_unit #(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [dataWidth-1:0]   inputA,
    input  logic [dataWidth-1:0]   inputB,
    input  logic [selectWidth-1:0] ALUSelect,
    output logic [dataWidth-1:0]   dataOut,
    output logic [dataWidth-1:0]   dataOutHigh
);

    typedef enum logic [selectWidth-1:0] {
        OP_ADD = 'd0,
        OP_SUB = 'd1,
        OP_MUL = 'd2,
        OP_AND = 'd3,
        OP_OR  = 'd4,
        OP_XOR = 'd5,
        OP_NOT = 'd6,
        OP_SLL = 'd7,
        OP_SRL = 'd8
    } alu_op_t;

    localparam logic [dataWidth-1:0] SHIFT_LIMIT = dataWidth'(dataWidth);

    logic [2*dataWidth-1:0] product;
    logic                   shift_oob;
    logic [dataWidth-1:0]   next_low;
    logic [dataWidth-1:0]   next_high;

    assign product   = {{dataWidth{1'b0}}, inputA} * {{dataWidth{1'b0}}, inputB};
    // The whole of inputB is the shift amount, so anything past the width clears.
    assign shift_oob = (inputB >= SHIFT_LIMIT);

    always_comb begin
        next_low  = '0;
        next_high = '0;
        case (alu_op_t'(ALUSelect))
            OP_ADD: next_low = inputA + inputB;
            OP_SUB: next_low = inputA - inputB;
            OP_MUL: begin
                next_low  = product[dataWidth-1:0];
                next_high = product[2*dataWidth-1:dataWidth];
            end
            OP_AND: next_low = inputA & inputB;
            OP_OR:  next_low = inputA | inputB;
            OP_XOR: next_low = inputA ^ inputB;
            OP_NOT: next_low = ~inputA;
            OP_SLL: next_low = shift_oob ? '0 : (inputA << inputB);
            OP_SRL: next_low = shift_oob ? '0 : (inputA >> inputB);
            default: begin
                next_low  = '0;
                next_high = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut     <= '0;
            dataOutHigh <= '0;
        end else begin
            dataOut     <= next_low;
            dataOutHigh <= next_high;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: expected {high,low} pushed when an operation
// is driven, popped and compared one rising edge later.
module tb_alu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic [3:0]  ALUSelect;
    logic [31:0] dataOut;
    logic [31:0] dataOutHigh;

    int checks;
    int fails;

    logic [63:0] exp_q[$];

    alu_unit #(.dataWidth(32), .selectWidth(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .inputA     (inputA),
        .inputB     (inputB),
        .ALUSelect  (ALUSelect),
        .dataOut    (dataOut),
        .dataOutHigh(dataOutHigh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model used for the randomised traffic only.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        case (op)
            4'd0: model = {32'h0, 32'(a + b)};
            4'd1: model = {32'h0, 32'(a - b)};
            4'd2: begin
                p = 64'(a) * 64'(b);
                model = p;
            end
            4'd3: model = {32'h0, a & b};
            4'd4: model = {32'h0, a | b};
            4'd5: model = {32'h0, a ^ b};
            4'd6: model = {32'h0, ~a};
            4'd7: model = (b > 32'd31) ? 64'h0 : {32'h0, a << b[4:0]};
            4'd8: model = (b > 32'd31) ? 64'h0 : {32'h0, a >> b[4:0]};
            default: model = 64'h0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        ALUSelect = op;
        inputA    = a;
        inputB    = b;
        exp_q.push_back(exp);
    endtask

    task automatic test_reset;
        logic [63:0] e;
        reset = 1'b0;
        drive(4'd0, 32'd8, 32'd8, {32'h0, 32'h10});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({dataOutHigh, dataOut} !== 64'h0) begin
                fails++;
                $display("FAIL reset_hold: got %h_%h expected 0", dataOutHigh, dataOut);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if ({dataOutHigh, dataOut} !== e) begin
            fails++;
            $display("FAIL reset_release: got %h_%h expected %h", dataOutHigh, dataOut, e);
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        ALUSelect = 4'd2; inputA = 32'hFFFFFFFF; inputB = 32'hFFFFFFFF;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({dataOutHigh, dataOut} !== 64'h0) begin
            fails++;
            $display("FAIL reset_async: got %h_%h expected 0", dataOutHigh, dataOut);
        end
        ALUSelect = 4'd0; inputA = 32'd5; inputB = 32'd6;
        @(posedge clk); #1;
        checks++;
        if ({dataOutHigh, dataOut} !== 64'h0) begin
            fails++;
            $display("FAIL reset_discard: got %h_%h expected 0", dataOutHigh, dataOut);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back({32'h0, 32'd11});
        @(posedge clk); #1;
        begin
            logic [63:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({dataOutHigh, dataOut} !== e) begin
                fails++;
                $display("FAIL reset_recover: got %h_%h expected %h", dataOutHigh, dataOut, e);
            end
        end
    endtask

    task automatic run_vectors(input string name, input logic [3:0] ops[],
                               input logic [31:0] as[], input logic [31:0] bs[],
                               input logic [63:0] es[]);
        logic [63:0] e;
        for (int i = 0; i < ops.size(); i++) begin
            @(negedge clk);
            drive(ops[i], as[i], bs[i], es[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({dataOutHigh, dataOut} !== e) begin
                fails++;
                $display("FAIL %s[%0d]: op=%0d got %h_%h expected %h",
                         name, i, ops[i], dataOutHigh, dataOut, e);
            end
        end
    endtask

    task automatic test_add_sub;
        run_vectors("add_sub", '{4'd0, 4'd1, 4'd1, 4'd0},
                    '{32'd8, 32'd3, 32'd7, 32'hFFFFFFFF},
                    '{32'd7, 32'd7, 32'd7, 32'd1},
                    '{64'h0F, 64'hFFFFFFFC, 64'h0, 64'h0});
    endtask

    task automatic test_mul;
        run_vectors("mul", '{4'd2, 4'd2, 4'd2},
                    '{32'd3, 32'hFFFFFFFF, 32'h00010000},
                    '{32'd7, 32'hFFFFFFFF, 32'h00010000},
                    '{64'h15, 64'hFFFFFFFE_00000001, 64'h00000001_00000000});
    endtask

    task automatic test_logic;
        run_vectors("logic", '{4'd3, 4'd3, 4'd4, 4'd5, 4'd6},
                    '{32'hF0F0F0F0, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hFFFF0000, 32'h12345678},
                    '{32'h0F0F0F0F, 32'h12345678, 32'h0F0F0F0F, 32'h00FFFF00, 32'hDEADBEEF},
                    '{64'h0, 64'h12345678, 64'hFFFFFFFF, 64'hFF00FF00, 64'hEDCBA987});
    endtask

    task automatic test_shift;
        run_vectors("shift", '{4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd7, 4'd8, 4'd7},
                    '{32'd1, 32'd1, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'd1,
                      32'hFFFFFFFF, 32'hFFFFFFFF},
                    '{32'd1, 32'd32, 32'd31, 32'd1, 32'd0, 32'd31,
                      32'h00000120, 32'd4},
                    '{64'h2, 64'h0, 64'h1, 64'h1, 64'hFFFFFFFF, 64'h80000000,
                      64'h0, 64'hFFFFFFF0});
    endtask

    task automatic test_illegal;
        run_vectors("illegal", '{4'd12, 4'd9, 4'd15},
                    '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                    '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                    '{64'h0, 64'h0, 64'h0});
    endtask

    // New opcode every cycle; each result must appear exactly one edge later.
    task automatic test_back_to_back;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            op = 4'(i % 16);
            a  = $urandom;
            b  = (op == 4'd7 || op == 4'd8) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            drive(op, a, b, model(op, a, b));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            checks++;
            if ({dataOutHigh, dataOut} !== e) begin
                fails++;
                $display("FAIL back_to_back[%0d]: op=%0d a=%h b=%h got %h_%h expected %h",
                         i, op, a, b, dataOutHigh, dataOut, e);
            end
        end
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        reset     = 1'b0;
        inputA    = '0;
        inputB    = '0;
        ALUSelect = '0;
        test_reset;
        test_add_sub;
        test_mul;
        test_logic;
        test_shift;
        test_illegal;
        test_reset_midop;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
